// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, constants and next-PC select encoding for the MIPS fetch stage
package mips_pkg;
   localparam int INSTR_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] PC_INC = 32'd4;
   typedef enum logic [1:0] {SEL_SEQ, SEL_HOLD, SEL_BRANCH, SEL_JUMP} pc_sel_e;
endpackage

// File: rtl/fetch_target_gen.sv
// fetch_target_gen: branch/jump target formation and next-PC priority select
module fetch_target_gen
   import mips_pkg::*;
(
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [ADDR_W-1:0] pc_plus4_i,
   input  logic              valid_i,
   input  logic              stall_i,
   input  logic              branch_taken_i,
   input  logic [15:0]       branch_offset_i,
   input  logic              jump_i,
   input  logic [25:0]       jump_index_i,
   output pc_sel_e           sel_o,
   output logic [ADDR_W-1:0] next_pc_o
);
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] jump_target;
   logic [ADDR_W-1:0] seq_pc;
   // a bubble in IF/ID carries no ID decision, so stall and redirects only count when valid
   always_comb begin
      branch_target = (pc_plus4_i + {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00}) & ~32'd3;
      jump_target = {pc_plus4_i[31:28], jump_index_i, 2'b00};
      seq_pc = (pc_i + PC_INC) & ~32'd3;
      sel_o = !valid_i ? SEL_SEQ : stall_i ? SEL_HOLD : branch_taken_i ? SEL_BRANCH : jump_i ? SEL_JUMP : SEL_SEQ;
      next_pc_o = sel_o == SEL_HOLD ? pc_i : sel_o == SEL_BRANCH ? branch_target : sel_o == SEL_JUMP ? jump_target : seq_pc;
   end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC and IF/ID register with stall, branch/jump redirect and fetch count
module instruction_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int FETCH_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   id_branch_taken,
   input  logic [15:0]            id_branch_offset,
   input  logic                   id_jump,
   input  logic [25:0]            id_jump_index,
   output logic [ADDR_W-1:0]      imem_addr,
   input  logic [INSTR_W-1:0]     imem_instr,
   output logic [ADDR_W-1:0]      pc,
   output logic [INSTR_W-1:0]     if_id_instr,
   output logic [ADDR_W-1:0]      if_id_pc_plus4,
   output logic                   if_id_valid,
   output logic [FETCH_CNT_W-1:0] fetch_count
);
   localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC & ~32'd3;
   pc_sel_e sel;
   logic [ADDR_W-1:0] next_pc;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] pp4_q, pp4_d;
   logic valid_q, valid_d;
   logic [FETCH_CNT_W-1:0] cnt_q, cnt_d;
   fetch_target_gen u_tgt (
      .pc_i(pc_q),
      .pc_plus4_i(pp4_q),
      .valid_i(valid_q),
      .stall_i(stall),
      .branch_taken_i(id_branch_taken),
      .branch_offset_i(id_branch_offset),
      .jump_i(id_jump),
      .jump_index_i(id_jump_index),
      .sel_o(sel),
      .next_pc_o(next_pc)
   );
   // sequential fetch loads IF/ID, stall holds it, a redirect flushes it to a nop bubble
   always_comb begin
      pc_d = next_pc;
      instr_d = sel == SEL_SEQ ? imem_instr : sel == SEL_HOLD ? instr_q : NOP_INSTR;
      pp4_d = sel == SEL_SEQ ? next_pc : sel == SEL_HOLD ? pp4_q : '0;
      valid_d = sel == SEL_SEQ ? 1'b1 : sel == SEL_HOLD ? valid_q : 1'b0;
      cnt_d = (sel == SEL_SEQ && !(&cnt_q)) ? cnt_q + FETCH_CNT_W'(1) : cnt_q;
   end
   // PC and IF/ID state; reset dominates stall and redirects on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC_A;
         instr_q <= NOP_INSTR;
         pp4_q <= '0;
         valid_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         pc_q <= pc_d;
         instr_q <= instr_d;
         pp4_q <= pp4_d;
         valid_q <= valid_d;
         cnt_q <= cnt_d;
      end
   end
   assign imem_addr = pc_q;
   assign pc = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc_plus4 = pp4_q;
   assign if_id_valid = valid_q;
   assign fetch_count = cnt_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios plus randomized run against a behavioural fetch model
module tb_instruction_fetch_unit;
   logic clk = 0;
   logic rst = 1, stall = 0, br = 0, jp = 0;
   logic [15:0] off = 0;
   logic [25:0] idx = 0;
   logic [31:0] imem_addr, imem_instr, pc, instr, pp4;
   logic valid;
   logic [15:0] cnt;
   logic rst_w = 1;
   logic [31:0] imem_addr_w, imem_instr_w, pc_w, instr_w, pp4_w;
   logic valid_w;
   logic [1:0] cnt_w;
   int errors = 0, checks = 0;
   logic [31:0] m_pc, m_instr, m_pp4;
   logic m_valid;
   logic [15:0] m_cnt;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      logic [31:0] w;
      w = (a * 32'h0100_0193) ^ 32'hA5A5_3C3C;
      return (a[5:2] == 4'h5) ? 32'h0 : w;
   endfunction

   assign imem_instr = mem(imem_addr);
   assign imem_instr_w = mem(imem_addr_w);

   instruction_fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .id_branch_taken(br), .id_branch_offset(off),
      .id_jump(jp), .id_jump_index(idx), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .pc(pc), .if_id_instr(instr), .if_id_pc_plus4(pp4), .if_id_valid(valid), .fetch_count(cnt)
   );

   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .FETCH_CNT_W(2)) dut_w (
      .clk(clk), .rst(rst_w), .stall(1'b0), .id_branch_taken(1'b0), .id_branch_offset(16'h0),
      .id_jump(1'b0), .id_jump_index(26'h0), .imem_addr(imem_addr_w), .imem_instr(imem_instr_w),
      .pc(pc_w), .if_id_instr(instr_w), .if_id_pc_plus4(pp4_w), .if_id_valid(valid_w), .fetch_count(cnt_w)
   );

   task automatic model_edge();
      logic [31:0] sext;
      sext = {{16{off[15]}}, off};
      if (rst) begin
         m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_cnt = 0;
      end else if (m_valid && stall) begin
      end else if (m_valid && (br || jp)) begin
         m_pc = br ? m_pp4 + sext * 4 : {m_pp4[31:28], idx, 2'b00};
         m_instr = 0; m_pp4 = 0; m_valid = 0;
      end else begin
         m_instr = mem(m_pc);
         m_pc = m_pc + 4;
         m_pp4 = m_pc;
         m_valid = 1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; stall = 0; br = 0; jp = 0; off = 0; idx = 0;
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want %h", instr, 32'h0); end
      checks++; if (pp4 !== 32'h0) begin errors++; $display("FAIL reset_pp4 got %h want %h", pp4, 32'h0); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
      checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
   endtask

   task automatic test_sequential();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d got %h want %h", i, imem_addr, 32'(4 * i)); end
         step();
         checks++; if (pp4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL seq_pp4%0d got %h want %h", i, pp4, 32'(4 * i + 4)); end
         checks++; if (instr !== mem(32'(4 * i)) || valid !== 1'b1) begin errors++; $display("FAIL seq_instr%0d got %h/%b want %h/1", i, instr, valid, mem(32'(4 * i))); end
      end
      checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL seq_cnt got %0d want 3", cnt); end
   endtask

   task automatic test_stall();
      do_reset();
      step(); step();
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (pc !== 32'd8 || pp4 !== 32'd8 || instr !== mem(32'd4) || valid !== 1'b1) begin errors++; $display("FAIL stall%0d got pc=%h pp4=%h instr=%h v=%b want pc=8 pp4=8 instr=%h v=1", i, pc, pp4, instr, valid, mem(32'd4)); end
         checks++; if (cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt%0d got %0d want 2", i, cnt); end
      end
      stall = 0;
      step();
      checks++; if (pc !== 32'd12) begin errors++; $display("FAIL stall_release got %h want %h", pc, 32'd12); end
   endtask

   task automatic test_branch();
      do_reset();
      repeat (9) step();
      checks++; if (pp4 !== 32'd36) begin errors++; $display("FAIL br_setup got %h want %h", pp4, 32'd36); end
      br = 1; off = 16'h0009;
      step();
      br = 0;
      checks++; if (pc !== 32'd72) begin errors++; $display("FAIL br_pc got %h want %h", pc, 32'd72); end
      checks++; if (valid !== 1'b0 || instr !== 32'h0 || pp4 !== 32'h0) begin errors++; $display("FAIL br_flush got v=%b instr=%h pp4=%h want 0/0/0", valid, instr, pp4); end
   endtask

   task automatic test_neg_jump();
      do_reset();
      repeat (16) step();
      br = 1; off = 16'hFFFF;
      step();
      br = 0;
      checks++; if (pc !== 32'h3C) begin errors++; $display("FAIL negbr_pc got %h want %h", pc, 32'h3C); end
      repeat (3) step();
      checks++; if (pp4 !== 32'h48) begin errors++; $display("FAIL jmp_setup got %h want %h", pp4, 32'h48); end
      jp = 1; idx = 26'h0E;
      step();
      jp = 0;
      checks++; if (pc !== 32'h38) begin errors++; $display("FAIL jmp_pc got %h want %h", pc, 32'h38); end
      checks++; if (valid !== 1'b0 || instr !== 32'h0 || cnt !== 16'd19) begin errors++; $display("FAIL jmp_flush got v=%b instr=%h cnt=%0d want 0/0/19", valid, instr, cnt); end
   endtask

   task automatic test_priority();
      do_reset();
      step(); step();
      stall = 1; br = 1; jp = 1; off = 16'h0004; idx = 26'h100;
      step();
      checks++; if (pc !== 32'd8 || valid !== 1'b1) begin errors++; $display("FAIL prio_stall got pc=%h v=%b want pc=8 v=1", pc, valid); end
      stall = 0;
      step();
      br = 0; jp = 0;
      checks++; if (pc !== 32'd24 || valid !== 1'b0) begin errors++; $display("FAIL prio_branch got pc=%h v=%b want pc=18 v=0", pc, valid); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      repeat (3) step();
      stall = 1;
      step();
      rst = 1;
      step();
      rst = 0; stall = 0;
      checks++; if (pc !== 32'h0 || instr !== 32'h0 || pp4 !== 32'h0 || valid !== 1'b0 || cnt !== 16'h0) begin errors++; $display("FAIL rst_stall got pc=%h instr=%h pp4=%h v=%b cnt=%0d want all 0", pc, instr, pp4, valid, cnt); end
   endtask

   task automatic test_wrap();
      rst_w = 1;
      step();
      checks++; if (pc_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_pc got %h want %h", pc_w, 32'hFFFF_FFFC); end
      rst_w = 0;
      step();
      checks++; if (pc_w !== 32'h0 || pp4_w !== 32'h0 || valid_w !== 1'b1) begin errors++; $display("FAIL wrap got pc=%h pp4=%h v=%b want 0/0/1", pc_w, pp4_w, valid_w); end
      checks++; if (instr_w !== mem(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr got %h want %h", instr_w, mem(32'hFFFF_FFFC)); end
      repeat (4) step();
      checks++; if (cnt_w !== 2'd3) begin errors++; $display("FAIL cnt_saturate got %0d want 3", cnt_w); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         stall = ($urandom_range(0, 3) == 0);
         br = ($urandom_range(0, 6) == 0);
         jp = ($urandom_range(0, 6) == 0);
         off = 16'($urandom);
         idx = 26'($urandom_range(0, 255));
         step();
         checks++; if (pc !== m_pc || imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pc%0d got %h/%h want %h", i, pc, imem_addr, m_pc); end
         checks++; if (instr !== m_instr || pp4 !== m_pp4 || valid !== m_valid) begin errors++; $display("FAIL rnd_ifid%0d got %h/%h/%b want %h/%h/%b", i, instr, pp4, valid, m_instr, m_pp4, m_valid); end
         checks++; if (cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt%0d got %0d want %0d", i, cnt, m_cnt); end
      end
      rst = 0; stall = 0; br = 0; jp = 0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_neg_jump();
      test_priority();
      test_reset_mid_stall();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Instruction fetch (IF) stage of the pipelined MIPS core. It owns the program counter and drives the byte address to the instruction memory. It latches the returned instruction word into the IF/ID pipeline register. It also forms branch and jump redirect targets from fields that the ID stage supplies, and it stalls or flushes under hazard-unit control.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; low two bits are forced to 0.
FETCH_CNT_W, 16, width of the saturating count of valid fetches.

Ports:
clk  input  1  rising-edge clock; the only clock in the block.
rst  input  1  synchronous, active-high reset.
stall  input  1  from the hazard unit; freezes the PC and IF/ID.
id_branch_taken  input  1  from ID: the beq/bne currently in IF/ID is resolved as taken.
id_branch_offset  input  16  from ID: immediate field of the branch in IF/ID.
id_jump  input  1  from ID: the instruction in IF/ID is a j.
id_jump_index  input  26  from ID: instr[25:0] of the j.
imem_addr  output  32  byte address to the instruction memory; the memory indexes it as addr>>2.
imem_instr  input  32  combinational instruction word returned for imem_addr.
pc  output  32  current PC (debug/display).
if_id_instr  output  32  registered instruction word.
if_id_pc_plus4  output  32  registered PC+4 of if_id_instr.
if_id_valid  output  1  1 when IF/ID holds a real fetched instruction; 0 for a bubble.
fetch_count  output  FETCH_CNT_W  number of valid instructions loaded into IF/ID; saturates.

Behaviour:
- imem_addr = pc, combinational, no latency. Instruction-to-IF/ID latency is 1 cycle.
- pc[1:0] is always 2'b00. Every target has bits [1:0] forced to 0.
- Targets are combinational and computed from the registered if_id_pc_plus4:
  - branch_target = if_id_pc_plus4 + (sign_extend(id_branch_offset) << 2), modulo 2^32.
  - jump_target = {if_id_pc_plus4[31:28], id_jump_index, 2'b00}.
- Per rising edge, highest priority first:
  1. rst:
     - pc <= RESET_PC & ~3.
     - if_id_instr <= 32'h0, if_id_pc_plus4 <= 0, if_id_valid <= 0.
     - fetch_count <= 0.
  2. stall:
     - pc and all IF/ID registers hold.
     - Redirect inputs are ignored this cycle, because an ID decision made under stall is not valid.
  3. id_branch_taken:
     - pc <= branch_target.
     - IF/ID is flushed: if_id_instr <= 0 (nop), if_id_pc_plus4 <= 0, if_id_valid <= 0.
  4. id_jump, with no branch taken: pc <= jump_target, with the same flush as a branch. If both redirects are asserted, the branch wins.
  5. Normal:
     - pc <= pc + 4. At pc = 32'hFFFFFFFC this wraps to 0.
     - if_id_instr <= imem_instr, if_id_pc_plus4 <= pc + 4, if_id_valid <= 1.
     - fetch_count increments, saturating at all-ones.
- An imem_instr of 32'h0 (the memory default) is latched as a valid nop; it is not treated as a halt.
- Reset asserted mid-stall or mid-redirect takes effect on that edge. The first fetch after reset deassertion uses address RESET_PC.
- Redirect and stall inputs are ignored while if_id_valid = 0; a bubble carries no ID decision.
- Every output has a defined value from the first reset edge; no X propagates from the IF/ID registers.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INSTR = 32'h00000000;
  - INSTR_W = 32, ADDR_W = 32;
  - the PC increment constant 4.
- One natural sub-module: fetch_target_gen. It is purely combinational: sign-extend/shift/add for the branch target, concatenation for the jump target, and the next-PC priority mux select.
- PC and IF/ID registers stay in the top module.

Test Plan:
- Reset, then 3 free-running cycles with an imem model returning addr-dependent words -> imem_addr 0, 4, 8; if_id_pc_plus4 4, 8, 12; if_id_valid = 1; fetch_count = 3.
- stall = 1 for 2 cycles at pc = 8 -> pc stays 8, IF/ID unchanged, fetch_count unchanged. Release -> pc = 12 next edge.
- Branch taken, offset 16'h0009:
  - Setup: IF/ID holds the beq at pc 32 (if_id_pc_plus4 = 36); assert id_branch_taken with offset 16'h0009.
  - Required: next pc = 72 (word 18), if_id_valid = 0, if_id_instr = 0.
- Negative offset and jump:
  - Offset 16'hFFFF with if_id_pc_plus4 = 0x40 -> pc = 0x3C.
  - id_jump with index 26'h0E and if_id_pc_plus4 = 0x48 -> pc = 0x38, IF/ID flushed.
- Priority:
  - stall, id_branch_taken and id_jump all high -> pc holds.
  - Drop stall with both redirects still high -> branch target is taken.
- Wrap and reset:
  - RESET_PC = 32'hFFFFFFFC, one normal cycle -> pc = 0, if_id_pc_plus4 = 0.
  - rst asserted during a stall -> all outputs return to their reset values on that edge.
